// File: rtl/lcd_spi_tx_if.sv
// lcd_spi_tx_if: byte handshake between the LCD init/draw sequencer and lcd_spi_tx.
// The sequencer uses the master modport and the transmitter uses the slave modport.
interface lcd_spi_tx_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_last;
    logic       busy;

    modport master (
        output tx_valid, tx_data, tx_dc, tx_last,
        input  tx_ready, busy
    );

    modport slave (
        input  tx_valid, tx_data, tx_dc, tx_last,
        output tx_ready, busy
    );
endinterface

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: byte-level SPI mode-0 (CPOL=0, CPHA=0) transmitter for the LCD panel.
// Shifts one byte MSB-first per handshake and drives chip-select and D/C.
// Define LCD_SPI_BURST_EN to keep CS asserted across bytes until one tagged tx_last.
module lcd_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    lcd_spi_tx_if.slave tx,
    output logic        lcd_spi_sclk,
    output logic        lcd_spi_mosi,
    output logic        lcd_spi_cs,
    output logic        lcd_dc
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_TAIL  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
`ifdef LCD_SPI_BURST_EN
    localparam logic [2:0] ST_WAIT  = 3'd4;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] div_q,   div_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] data_q,  data_d;
    logic       sclk_q,  sclk_d;
    logic       mosi_q,  mosi_d;
    logic       cs_q,    cs_d;
    logic       dc_q,    dc_d;
`ifdef LCD_SPI_BURST_EN
    logic       last_q,  last_d;
`else
    logic       unused_last;
    assign unused_last = tx.tx_last;
`endif

    logic accept;
    logic div_wrap;

`ifdef LCD_SPI_BURST_EN
    assign tx.tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
`else
    assign tx.tx_ready = (state_q == ST_IDLE);
`endif
    assign tx.busy   = (state_q != ST_IDLE);
    assign accept    = tx.tx_valid && tx.tx_ready;
    assign div_wrap  = (div_q == DIV_LAST);

    assign lcd_spi_sclk = sclk_q;
    assign lcd_spi_mosi = mosi_q;
    assign lcd_spi_cs   = cs_q;
    assign lcd_dc       = dc_q;

    // Next-state logic: handshake capture, SCLK phase/bit sequencing, CS hold and deselect timing.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
`ifdef LCD_SPI_BURST_EN
        last_d  = last_q;
`endif
        if (accept) begin
            state_d = ST_SHIFT;
            div_d   = '0;
            bit_d   = 3'd7;
            data_d  = tx.tx_data;
            sclk_d  = 1'b0;
            mosi_d  = tx.tx_data[7];
            cs_d    = 1'b0;
            dc_d    = tx.tx_dc;
`ifdef LCD_SPI_BURST_EN
            last_d  = tx.tx_last;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    div_d = div_wrap ? '0 : div_q + 8'd1;
                    if (div_wrap) begin
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                        end else begin
                            sclk_d = 1'b0;
                            if (bit_q != 3'd0) begin
                                bit_d  = bit_q - 3'd1;
                                mosi_d = data_q[bit_q - 3'd1];
                            end else begin
`ifdef LCD_SPI_BURST_EN
                                state_d = last_q ? ST_TAIL : ST_WAIT;
`else
                                state_d = ST_TAIL;
`endif
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    div_d = div_wrap ? '0 : div_q + 8'd1;
                    if (div_wrap) begin
                        state_d = ST_GAP;
                        cs_d    = 1'b1;
                    end
                end
                ST_GAP: begin
                    div_d = div_wrap ? '0 : div_q + 8'd1;
                    if (div_wrap) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // IDLE and WAIT hold every pin and counter until the next accept
                end
            endcase
        end
    end

    // State and pin registers with synchronous reset to the idle pin levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
`ifdef LCD_SPI_BURST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
`ifdef LCD_SPI_BURST_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule
